// File: rtl/eth_arp_pkg.sv
// Shared ARP definitions for the eth_video ARP receiver and transmitter:
// EtherType, opcodes, preamble/SFD bytes, field lengths and one-hot FSM states.
package eth_arp_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam int unsigned ETH_HEAD_LEN  = 14;
  localparam int unsigned ARP_DATA_LEN  = 28;
  localparam int unsigned CNT_W         = 6;

  typedef enum logic [4:0] {
    st_idle     = 5'b00001,
    st_preamble = 5'b00010,
    st_eth_head = 5'b00100,
    st_arp_data = 5'b01000,
    st_rx_end   = 5'b10000
  } arp_state_e;

endpackage

// File: rtl/video_trans_eth_arp_rx.sv
// GMII ARP receiver: parses preamble/SFD, Ethernet header and the 28-byte ARP
// payload, filters on destination MAC, EtherType and target IP, and reports
// opcode plus sender MAC/IP of every accepted packet.
// Ports:
//   clk, rst_n    - GMII rx clock, async active-low reset
//   gmii_rx_dv    - receive data valid
//   gmii_rxd      - receive byte
//   arp_rx_done   - one-cycle pulse per accepted ARP packet
//   arp_rx_type   - 0 = request, 1 = reply
//   src_mac       - sender MAC of last accepted packet
//   src_ip        - sender IP of last accepted packet
module video_trans_eth_arp_rx
  import eth_arp_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  localparam logic [CNT_W-1:0] SFD_CNT   = CNT_W'(6);
  localparam logic [CNT_W-1:0] MAC_DONE  = CNT_W'(6);
  localparam logic [CNT_W-1:0] TYPE_HI   = CNT_W'(12);
  localparam logic [CNT_W-1:0] HEAD_LAST = CNT_W'(ETH_HEAD_LEN - 1);
  localparam logic [CNT_W-1:0] ARP_LAST  = CNT_W'(ARP_DATA_LEN - 1);
  localparam logic [47:0]      BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  arp_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [47:0]      r_dst_mac;
  logic [15:0]      r_op;
  logic [47:0]      r_sndr_mac;
  logic [31:0]      r_sndr_ip;
  logic [23:0]      r_tgt_ip;
  logic             r_done_t;

  logic w_dst_ok;
  logic w_op_ok;
  logic w_tgt_ok;

  // Destination is checked once all six bytes have been shifted in.
  assign w_dst_ok = (r_dst_mac == BOARD_MAC) || (r_dst_mac == BCAST_MAC);
  assign w_op_ok  = (r_op == ARP_OP_REQ) || (r_op == ARP_OP_REPLY);
  // Last target-IP byte is compared straight off the bus.
  assign w_tgt_ok = ({r_tgt_ip, gmii_rxd} == BOARD_IP);

  // Receive FSM with capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= st_idle;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_dst_mac  <= '0;
      r_op       <= '0;
      r_sndr_mac <= '0;
      r_sndr_ip  <= '0;
      r_tgt_ip   <= '0;
      r_done_t   <= 1'b0;
    end else begin
      r_done_t <= 1'b0;
      case (r_state)
        st_idle: begin
          r_cnt <= '0;
          if (gmii_rx_dv && (gmii_rxd == PREAMBLE_BYTE)) begin
            r_state    <= st_preamble;
            r_err      <= 1'b0;
            r_dst_mac  <= '0;
            r_op       <= '0;
            r_sndr_mac <= '0;
            r_sndr_ip  <= '0;
            r_tgt_ip   <= '0;
          end
        end

        st_preamble: begin
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
            r_cnt   <= '0;
          end else if (r_cnt < SFD_CNT) begin
            if (gmii_rxd == PREAMBLE_BYTE) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_state <= st_rx_end;
              r_cnt   <= '0;
            end
          end else begin
            r_state <= (gmii_rxd == SFD_BYTE) ? st_eth_head : st_rx_end;
            r_cnt   <= '0;
          end
        end

        st_eth_head: begin
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt < MAC_DONE) begin
              r_dst_mac <= {r_dst_mac[39:0], gmii_rxd};
            end
            if ((r_cnt == MAC_DONE) && !w_dst_ok) begin
              r_err <= 1'b1;
            end
            if ((r_cnt == TYPE_HI) && (gmii_rxd != ETH_TYPE_ARP[15:8])) begin
              r_err <= 1'b1;
            end
            if (r_cnt == HEAD_LAST) begin
              r_cnt   <= '0;
              r_state <= (r_err || (gmii_rxd != ETH_TYPE_ARP[7:0])) ? st_rx_end : st_arp_data;
            end
          end
        end

        st_arp_data: begin
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if ((r_cnt == CNT_W'(6)) || (r_cnt == CNT_W'(7))) begin
              r_op <= {r_op[7:0], gmii_rxd};
            end
            if ((r_cnt >= CNT_W'(8)) && (r_cnt <= CNT_W'(13))) begin
              r_sndr_mac <= {r_sndr_mac[39:0], gmii_rxd};
            end
            if ((r_cnt >= CNT_W'(14)) && (r_cnt <= CNT_W'(17))) begin
              r_sndr_ip <= {r_sndr_ip[23:0], gmii_rxd};
            end
            if ((r_cnt >= CNT_W'(24)) && (r_cnt <= CNT_W'(26))) begin
              r_tgt_ip <= {r_tgt_ip[15:0], gmii_rxd};
            end
            if (r_cnt == ARP_LAST) begin
              r_state  <= st_rx_end;
              r_cnt    <= '0;
              r_done_t <= w_op_ok && w_tgt_ok;
            end
          end
        end

        st_rx_end: begin
          r_cnt <= '0;
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
          end
        end

        default: begin
          r_state <= st_idle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output register: outputs change only for accepted packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= '0;
      src_ip      <= '0;
    end else begin
      arp_rx_done <= r_done_t;
      if (r_done_t) begin
        arp_rx_type <= (r_op == ARP_OP_REPLY);
        src_mac     <= r_sndr_mac;
        src_ip      <= r_sndr_ip;
      end
    end
  end

endmodule

// File: tb/tb_video_trans_eth_arp_rx.sv
// Self-checking bench for video_trans_eth_arp_rx: builds whole GMII frames as
// byte queues, predicts acceptance from the frame fields, and checks pulse
// count, pulse latency and the reported sender addresses.
module tb_video_trans_eth_arp_rx;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10};
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam int          TIP_IDX   = 49;  // frame index of last target-IP byte

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  video_trans_eth_arp_rx #(
    .BOARD_MAC (BOARD_MAC),
    .BOARD_IP  (BOARD_IP)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .arp_rx_done (arp_rx_done),
    .arp_rx_type (arp_rx_type),
    .src_mac     (src_mac),
    .src_ip      (src_ip)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_pulse = 0;
  int pulse_cyc = -1;
  int tip_cyc   = -1;

  logic [47:0] exp_mac  = '0;
  logic [31:0] exp_ip   = '0;
  logic        exp_type = 1'b0;

  logic [7:0] fq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (arp_rx_done) begin
      n_pulse   = n_pulse + 1;
      pulse_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void build_frame(input logic [47:0] dst, input logic [15:0] et,
                                      input logic [15:0] op, input logic [47:0] smac,
                                      input logic [31:0] sip, input logic [31:0] tip);
    fq.delete();
    repeat (7) fq.push_back(8'h55);
    fq.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) fq.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) fq.push_back(smac[8*i +: 8]);
    fq.push_back(et[15:8]); fq.push_back(et[7:0]);
    fq.push_back(8'h00); fq.push_back(8'h01); fq.push_back(8'h08); fq.push_back(8'h00);
    fq.push_back(8'h06); fq.push_back(8'h04);
    fq.push_back(op[15:8]); fq.push_back(op[7:0]);
    for (int i = 5; i >= 0; i--) fq.push_back(smac[8*i +: 8]);
    for (int i = 3; i >= 0; i--) fq.push_back(sip[8*i +: 8]);
    repeat (6) fq.push_back(8'h00);
    for (int i = 3; i >= 0; i--) fq.push_back(tip[8*i +: 8]);
    repeat (18) fq.push_back(8'h00);
    repeat (4) fq.push_back(8'($urandom_range(0, 255)));
  endfunction

  task automatic drive_bytes(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b1;
      gmii_rxd   = fq[i];
      if (i == TIP_IDX) tip_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'h00;
    end
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ":mac"},  64'(src_mac),     64'(exp_mac));
    check_val({tag, ":ip"},   64'(src_ip),      64'(exp_ip));
    check_val({tag, ":type"}, 64'(arp_rx_type), 64'(exp_type));
  endtask

  // Build, drive and score one frame; trunc=0 sends it whole, bad_pre<0 leaves the preamble intact.
  task automatic run_frame(input string tag, input logic [47:0] dst, input logic [15:0] et,
                           input logic [15:0] op, input logic [47:0] smac,
                           input logic [31:0] sip, input logic [31:0] tip,
                           input int bad_pre, input int trunc, input int gap);
    int  len;
    int  p0;
    bit  acc;
    build_frame(dst, et, op, smac, sip, tip);
    if (bad_pre >= 0) fq[bad_pre] = 8'h54;
    len = (trunc > 0) ? trunc : fq.size();
    acc = ((dst == BOARD_MAC) || (dst == BCAST)) && (et == 16'h0806) &&
          ((op == 16'h0001) || (op == 16'h0002)) && (tip == BOARD_IP) &&
          (bad_pre < 0) && (len > TIP_IDX);
    p0 = n_pulse;
    tip_cyc = -1;
    drive_bytes(0, len);
    idle(gap);
    check_val({tag, ":pulses"}, 64'(n_pulse - p0), acc ? 64'd1 : 64'd0);
    if (acc) begin
      exp_mac  = smac;
      exp_ip   = sip;
      exp_type = (op == 16'h0002);
      check_val({tag, ":lat"}, 64'(pulse_cyc - tip_cyc), 64'd2);
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [47:0] smac;
    logic [31:0] sip;
    logic [47:0] dst;
    logic [15:0] et;
    logic [15:0] op;
    logic [31:0] tip;
    int          sel;
    int          bad;
    int          trunc;
    int          p0;

    rst_n = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rxd = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset:done", 64'(arp_rx_done), 64'd0);
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    run_frame("bcast_req", BCAST, 16'h0806, 16'h0001, 48'h000A3501FEC0, 32'hC0A80166,
              BOARD_IP, -1, 0, 3);
    run_frame("ucast_reply", BOARD_MAC, 16'h0806, 16'h0002, 48'h000A3501FEC0, 32'hC0A80166,
              BOARD_IP, -1, 0, 3);
    run_frame("bad_tip", BCAST, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80177,
              32'hC0A8010B, -1, 0, 3);
    run_frame("bad_dst", 48'h001122334456, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80177,
              BOARD_IP, -1, 0, 3);
    run_frame("bad_type", BCAST, 16'h0800, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80177,
              BOARD_IP, -1, 0, 3);
    // ARP byte 15 is frame index 8+14+15 = 37, so 38 bytes go out.
    run_frame("abort", BCAST, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80177,
              BOARD_IP, -1, 38, 1);
    run_frame("after_abort", BCAST, 16'h0806, 16'h0001, 48'h1234567890AB, 32'hC0A80105,
              BOARD_IP, -1, 0, 3);
    run_frame("bad_pre", BCAST, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80177,
              BOARD_IP, 3, 0, 3);
    run_frame("bad_op", BOARD_MAC, 16'h0806, 16'h0003, 48'h0A0B0C0D0E0F, 32'hC0A80177,
              BOARD_IP, -1, 0, 3);

    // Reset pulse during the Ethernet header.
    build_frame(BCAST, 16'h0806, 16'h0002, 48'h665544332211, 32'hC0A80199, BOARD_IP);
    p0 = n_pulse;
    drive_bytes(0, 12);
    @(negedge clk);
    gmii_rx_dv = 1'b1;
    gmii_rxd = fq[12];
    rst_n = 1'b0;
    #1;
    exp_mac = '0;
    exp_ip = '0;
    exp_type = 1'b0;
    check_val("midrst:done", 64'(arp_rx_done), 64'd0);
    check_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    gmii_rxd = fq[13];
    drive_bytes(14, fq.size());
    idle(3);
    check_val("midrst:pulses", 64'(n_pulse - p0), 64'd0);
    check_outputs("midrst_rest");
    run_frame("after_rst", BOARD_MAC, 16'h0806, 16'h0002, 48'hA1B2C3D4E5F6, 32'hC0A80120,
              BOARD_IP, -1, 0, 3);

    // Randomized frames mixing valid and each rejection cause.
    for (int n = 0; n < 40; n++) begin
      smac  = {16'($urandom), 32'($urandom)};
      sip   = 32'($urandom);
      dst   = ($urandom_range(0, 1) == 0) ? BCAST : BOARD_MAC;
      et    = 16'h0806;
      op    = ($urandom_range(0, 1) == 0) ? 16'h0001 : 16'h0002;
      tip   = BOARD_IP;
      bad   = -1;
      trunc = 0;
      sel   = int'($urandom_range(0, 9));
      case (sel)
        0: dst = BOARD_MAC ^ (48'd1 << $urandom_range(0, 47));
        1: et = 16'h0800;
        2: op = 16'($urandom_range(3, 65535));
        3: tip = BOARD_IP ^ (32'd1 << $urandom_range(0, 31));
        4: bad = int'($urandom_range(1, 6));
        5: trunc = int'($urandom_range(10, 60));
        default: ;
      endcase
      run_frame("rand", dst, et, op, smac, sip, tip, bad, trunc, int'($urandom_range(2, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
